// File: rtl/pipe_sum_unit.sv
// pipe_sum_unit: pipelined mantissa add/subtract with valid/ready handshake.
//
// The SIZE_DATA-bit carry chain is cut into NUM_STAGE segments of SEG_W bits.
// Stage k adds segment k using the carry that stage k-1 registered. Operands
// ride down the pipe with the partial result, so each stage finds its segment
// skew-delayed and the finished lower segments stay aligned with it. Only the
// last stage is visible on the outputs. The whole pipe freezes while the
// output holds a result that downstream has not taken.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_valid, o_ready    input handshake (o_ready = ~o_valid | i_ready)
//   i_sub, i_carry      0 = add, 1 = a - b; carry-in (add) or borrow-in (sub)
//   i_data_a, i_data_b  unsigned operands
//   o_valid, i_ready    output handshake
//   o_sum, o_carry      result; carry-out, which means "no borrow" in sub mode
//   o_zero              o_sum == 0, registered with o_sum
//
// SIZE_DATA must be divisible by NUM_STAGE, and 1 <= NUM_STAGE <= SIZE_DATA.
module pipe_sum_unit #(
  parameter int unsigned SIZE_DATA = 28,
  parameter int unsigned NUM_STAGE = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic                 i_sub,
  input  logic                 i_carry,
  input  logic [SIZE_DATA-1:0] i_data_a,
  input  logic [SIZE_DATA-1:0] i_data_b,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [SIZE_DATA-1:0] o_sum,
  output logic                 o_carry,
  output logic                 o_zero
);

  localparam int unsigned SegW = SIZE_DATA / NUM_STAGE;
  localparam int unsigned Last = NUM_STAGE - 1;

  // Per-stage state: operand A, effective operand B (already inverted for
  // subtract), partial sum, segment carry-out and valid.
  logic [SIZE_DATA-1:0] a_q [NUM_STAGE];
  logic [SIZE_DATA-1:0] b_q [NUM_STAGE];
  logic [SIZE_DATA-1:0] s_q [NUM_STAGE];
  logic                 c_q [NUM_STAGE];
  logic                 v_q [NUM_STAGE];
  logic                 zero_q;

  logic [SIZE_DATA-1:0] a_d [NUM_STAGE];
  logic [SIZE_DATA-1:0] b_d [NUM_STAGE];
  logic [SIZE_DATA-1:0] s_d [NUM_STAGE];
  logic                 cin [NUM_STAGE];
  logic                 c_d [NUM_STAGE];
  logic                 v_d [NUM_STAGE];
  logic                 zero_d;
  logic [SegW:0]        seg;
  logic                 en;

  assign en      = ~v_q[Last] | i_ready;
  assign o_ready = en;
  assign o_valid = v_q[Last];
  assign o_sum   = s_q[Last];
  assign o_carry = c_q[Last];
  assign o_zero  = zero_q;

  always_comb begin
    seg = '0;
    // Stage 0 takes the raw inputs; subtract is a + ~b + (borrow ^ 1).
    a_d[0] = i_data_a;
    b_d[0] = i_sub ? ~i_data_b : i_data_b;
    s_d[0] = '0;
    cin[0] = i_carry ^ i_sub;
    v_d[0] = i_valid;
    for (int unsigned k = 1; k < NUM_STAGE; k++) begin
      a_d[k] = a_q[k-1];
      b_d[k] = b_q[k-1];
      s_d[k] = s_q[k-1];
      cin[k] = c_q[k-1];
      v_d[k] = v_q[k-1];
    end
    for (int unsigned k = 0; k < NUM_STAGE; k++) begin
      seg = {1'b0, a_d[k][k*SegW +: SegW]} + {1'b0, b_d[k][k*SegW +: SegW]}
          + {{SegW{1'b0}}, cin[k]};
      s_d[k][k*SegW +: SegW] = seg[SegW-1:0];
      c_d[k] = seg[SegW];
    end
    zero_d = (s_d[Last] == '0);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned k = 0; k < NUM_STAGE; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        v_q[k] <= 1'b0;
      end
      zero_q <= 1'b0;
    end else if (en) begin
      for (int unsigned k = 0; k < NUM_STAGE; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
        c_q[k] <= c_d[k];
        v_q[k] <= v_d[k];
      end
      zero_q <= zero_d;
    end
  end

endmodule

// File: tb/tb_pipe_sum_unit.sv
// Bench for pipe_sum_unit: directed literal vectors plus a queue-based
// arithmetic model checked on every output transfer.
module tb_pipe_sum_unit;

  localparam int W = 28;
  localparam int N = 4;

  logic         i_clk = 1'b0;
  logic         i_rst, i_valid, i_sub, i_carry, i_ready;
  logic [W-1:0] i_data_a, i_data_b;
  logic         o_ready, o_valid, o_carry, o_zero;
  logic [W-1:0] o_sum;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int stalls   = 0;

  pipe_sum_unit #(.SIZE_DATA(W), .NUM_STAGE(N)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_sub   (i_sub),
    .i_carry (i_carry),
    .i_data_a(i_data_a),
    .i_data_b(i_data_b),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_sum   (o_sum),
    .o_carry (o_carry),
    .o_zero  (o_zero)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference: plain arithmetic on the operation, returns {carry, sum}.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic c, input logic sub);
    logic [63:0] wa, wb, d;
    wa = {36'b0, a};
    wb = {36'b0, b};
    if (!sub) begin
      d = wa + wb + {63'b0, c};
      return d[W:0];
    end
    d = wa - wb - {63'b0, c};
    return {(wa >= wb + {63'b0, c}), d[W-1:0]};
  endfunction

  typedef struct {
    logic [W:0] exp;
    int         acc_cyc;
    int         acc_stall;
  } exp_t;

  exp_t         q[$];
  logic         hold;
  logic [W+1:0] held;

  // Compare process: samples on the falling edge, away from the active edge.
  always @(negedge i_clk) begin
    exp_t e;
    if (i_rst === 1'b1) begin
      q.delete();
      hold = 1'b0;
    end else if (i_rst === 1'b0) begin
      if (hold) check("stall_hold", {o_valid, o_carry, o_zero, o_sum}, {1'b1, held});
      if (o_valid && i_ready) begin
        if (q.size() == 0) begin
          check("unexpected_result", {o_carry, o_sum}, 0);
          n_assert++;
          n_fail++;
          $display("FAIL spurious_output: got a result, expected none");
        end else begin
          e = q.pop_front();
          check("sum", o_sum, e.exp[W-1:0]);
          check("carry", o_carry, e.exp[W]);
          check("zero", o_zero, e.exp[W-1:0] == 0);
          check("latency", cyc - e.acc_cyc, N + stalls - e.acc_stall);
        end
      end
      hold = o_valid && !i_ready;
      held = {o_carry, o_zero, o_sum};
      if (!o_ready) stalls++;
      if (i_valid && o_ready) begin
        e.exp       = model(i_data_a, i_data_b, i_carry, i_sub);
        e.acc_cyc   = cyc;
        e.acc_stall = stalls;
        q.push_back(e);
      end
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Present one op and hold it until accepted; returns cycles spent.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                      input logic sub, output int tries);
    logic acc;
    i_data_a = a;
    i_data_b = b;
    i_carry  = c;
    i_sub    = sub;
    i_valid  = 1'b1;
    tries    = 0;
    do begin
      #1;
      acc = o_ready;
      @(posedge i_clk);
      #1;
      tries++;
    end while (!acc && tries < 30);
    if (!acc) check("send_timeout", 0, 1);
  endtask

  task automatic idle();
    i_valid = 1'b0;
  endtask

  // Single isolated op, then compare outputs against literal expectations.
  task automatic op_lit(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic sub, input logic [W-1:0] es,
                        input logic ec, input logic ez);
    int t;
    send(a, b, c, sub, t);
    idle();
    for (int i = 0; i < 20 && !o_valid; i++) step();
    check({name, "_valid"}, o_valid, 1);
    check({name, "_sum"}, o_sum, es);
    check({name, "_carry"}, o_carry, ec);
    check({name, "_zero"}, o_zero, ez);
    step();
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 60 && q.size() != 0; i++) step();
    check("drain_empty", q.size(), 0);
    repeat (2) step();
  endtask

  initial begin
    int t;
    i_rst = 1'b1; i_valid = 1'b0; i_sub = 1'b0; i_carry = 1'b0; i_ready = 1'b1;
    i_data_a = '0; i_data_b = '0;
    repeat (2) step();
    i_rst = 1'b0;
    check("rst_valid", o_valid, 0);
    check("rst_outputs", {o_sum, o_carry, o_zero}, 0);
    check("rst_ready", o_ready, 1);

    // Directed vectors.
    op_lit("wrap", 28'hFFFFFFF, 28'h0000001, 1'b0, 1'b0, 28'h0000000, 1'b1, 1'b1);
    op_lit("ripple", 28'h000007F, 28'h0000001, 1'b0, 1'b0, 28'h0000080, 1'b0, 1'b0);
    op_lit("ripple_cin", 28'h7FFFFFF, 28'h7FFFFFF, 1'b1, 1'b0, 28'hFFFFFFF, 1'b0, 1'b0);
    op_lit("sub_pos", 28'h0000005, 28'h0000003, 1'b0, 1'b1, 28'h0000002, 1'b1, 1'b0);
    op_lit("sub_neg", 28'h0000003, 28'h0000005, 1'b0, 1'b1, 28'hFFFFFFE, 1'b0, 1'b0);
    op_lit("sub_borrow", 28'h0000004, 28'h0000003, 1'b1, 1'b1, 28'h0000000, 1'b1, 1'b1);
    drain();

    // Streaming: 8 back-to-back random ops, each must be taken on first try.
    for (int i = 0; i < 8; i++) begin
      send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), t);
      check("stream_ready", t, 1);
    end
    idle();
    drain();

    // Backpressure: stall output for 3 cycles once a result shows up.
    fork
      begin
        for (int i = 0; i < 7; i++)
          send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), t);
        idle();
      end
      begin
        for (int i = 0; i < 20 && !o_valid; i++) step();
        i_ready = 1'b0;
        repeat (3) begin
          #1;
          check("bp_ready_low", o_ready, 0);
          check("bp_valid_high", o_valid, 1);
          @(posedge i_clk);
          #1;
        end
        i_ready = 1'b1;
      end
    join
    drain();

    // Reset mid-flight: 3 ops accepted, then discarded by reset.
    for (int i = 0; i < 3; i++) send(28'h0000100 + W'(i), 28'h0000001, 1'b0, 1'b0, t);
    i_rst   = 1'b1;
    i_valid = 1'b1;
    step();
    i_rst = 1'b0;
    idle();
    #1;
    check("midrst_valid", o_valid, 0);
    check("midrst_outputs", {o_sum, o_carry, o_zero}, 0);
    check("midrst_ready", o_ready, 1);
    repeat (8) begin
      check("midrst_no_ghost", o_valid, 0);
      step();
    end
    op_lit("post_rst", 28'h1234567, 28'h0ABCDEF, 1'b1, 1'b0, 28'h1CF1357, 1'b0, 1'b0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
